// File: rtl/ycbcr2rgb.sv
// 4:2:2 YCbCr to RGB888 converter: chroma pairing, BT.601 matrix, clamp, 5-cycle aligned sync/de.
// Optional macro YCBCR2RGB_FULLRANGE_EN selects full-range coefficients (default: limited range).
module ycbcr2rgb #(
  parameter bit swap_uv = 1'b0
) (
  input  logic        i_clk,
  input  logic        i_rst,
  input  logic        i_hsync,
  input  logic        i_vsync,
  input  logic        i_de,
  input  logic [17:0] i_YCbCr,
  output logic        o_hsync,
  output logic        o_vsync,
  output logic        o_de,
  output logic [23:0] o_rgb
);

`ifdef YCBCR2RGB_FULLRANGE_EN
  localparam logic [7:0]         Y_OFS = 8'd0;
  localparam logic signed [19:0] K_Y   = 20'sd256;
  localparam logic signed [19:0] K_RCR = 20'sd359;
  localparam logic signed [19:0] K_GCR = 20'sd183;
  localparam logic signed [19:0] K_GCB = 20'sd88;
  localparam logic signed [19:0] K_BCB = 20'sd454;
`else
  localparam logic [7:0]         Y_OFS = 8'd16;
  localparam logic signed [19:0] K_Y   = 20'sd298;
  localparam logic signed [19:0] K_RCR = 20'sd409;
  localparam logic signed [19:0] K_GCR = 20'sd208;
  localparam logic signed [19:0] K_GCB = 20'sd100;
  localparam logic signed [19:0] K_BCB = 20'sd516;
`endif
  localparam logic signed [19:0] ROUND = 20'sd128;

  // Bits [17:16] of the pixel word carry nothing for this stage.
  logic unused_hi;
  assign unused_hi = ^i_YCbCr[17:16];

  // Sync/de shift registers, independent of the data path
  logic [4:0] hs_sr, vs_sr, de_sr;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      hs_sr <= '0;
      vs_sr <= '0;
      de_sr <= '0;
    end else begin
      hs_sr <= {hs_sr[3:0], i_hsync};
      vs_sr <= {vs_sr[3:0], i_vsync};
      de_sr <= {de_sr[3:0], i_de};
    end
  end

  assign o_hsync = hs_sr[4];
  assign o_vsync = vs_sr[4];
  assign o_de    = de_sr[4];

  // S1/S2 sample registers
  logic [7:0] s1_y, s1_c, s2_y, s2_c;
  logic       s1_de, s1_par, s2_de, s2_par;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      s1_y   <= '0;
      s1_c   <= '0;
      s1_de  <= 1'b0;
      s1_par <= 1'b0;
      s2_y   <= '0;
      s2_c   <= '0;
      s2_de  <= 1'b0;
      s2_par <= 1'b0;
    end else begin
      s1_y   <= i_YCbCr[15:8];
      s1_c   <= i_YCbCr[7:0];
      s1_de  <= i_de;
      s1_par <= (i_de && s1_de) ? ~s1_par : 1'b0;
      s2_y   <= s1_y;
      s2_c   <= s1_c;
      s2_de  <= s1_de;
      s2_par <= s1_par;
    end
  end

  // Pairing: an even pixel in S2 looks one sample ahead (S1) for its odd partner.
  logic [7:0] cb_hold, cr_hold, cb_sel, cr_sel, even_c, odd_c;
  logic       pair_ok;

  assign pair_ok = s2_de && !s2_par && s1_de && s1_par;

  always_comb begin
    cb_sel = cb_hold;
    cr_sel = cr_hold;
    even_c = s2_c;
    odd_c  = pair_ok ? s1_c : 8'd128;
    if (s2_de && !s2_par) begin
      if (swap_uv) begin
        cb_sel = odd_c;
        cr_sel = even_c;
      end else begin
        cb_sel = even_c;
        cr_sel = odd_c;
      end
    end
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      cb_hold <= '0;
      cr_hold <= '0;
    end else if (pair_ok) begin
      cb_hold <= cb_sel;
      cr_hold <= cr_sel;
    end
  end

  // S3: offset removal and products
  logic signed [8:0]  yd, cbd, crd;
  logic signed [19:0] yd_x, cbd_x, crd_x;
  logic signed [19:0] p_y, p_rcr, p_gcr, p_gcb, p_bcb;
  logic               s3_de;

  always_comb begin
    yd    = $signed({1'b0, s2_y}) - $signed({1'b0, Y_OFS});
    cbd   = $signed({1'b0, cb_sel}) - 9'sd128;
    crd   = $signed({1'b0, cr_sel}) - 9'sd128;
    yd_x  = {{11{yd[8]}}, yd};
    cbd_x = {{11{cbd[8]}}, cbd};
    crd_x = {{11{crd[8]}}, crd};
  end

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      p_y   <= '0;
      p_rcr <= '0;
      p_gcr <= '0;
      p_gcb <= '0;
      p_bcb <= '0;
      s3_de <= 1'b0;
    end else begin
      p_y   <= yd_x * K_Y;
      p_rcr <= crd_x * K_RCR;
      p_gcr <= crd_x * K_GCR;
      p_gcb <= cbd_x * K_GCB;
      p_bcb <= cbd_x * K_BCB;
      s3_de <= s2_de;
    end
  end

  // S4: sums with rounding bias
  logic signed [19:0] r_sum, g_sum, b_sum;
  logic               s4_de;

  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      r_sum <= '0;
      g_sum <= '0;
      b_sum <= '0;
      s4_de <= 1'b0;
    end else begin
      r_sum <= p_y + p_rcr + ROUND;
      g_sum <= p_y - p_gcr - p_gcb + ROUND;
      b_sum <= p_y + p_bcb + ROUND;
      s4_de <= s3_de;
    end
  end

  // Upper 12 bits of the sum are the arithmetic >>8 result.
  function automatic logic [7:0] clamp8(input logic signed [19:0] s);
    logic signed [11:0] q;
    q = s[19:8];
    if (q < 12'sd0)
      clamp8 = 8'd0;
    else if (q > 12'sd255)
      clamp8 = 8'd255;
    else
      clamp8 = q[7:0];
  endfunction

  always_ff @(posedge i_clk) begin
    if (i_rst)
      o_rgb <= '0;
    else if (s4_de)
      o_rgb <= {clamp8(r_sum), clamp8(g_sum), clamp8(b_sum)};
    else
      o_rgb <= '0;
  end

endmodule

// File: tb/tb_ycbcr2rgb.sv
// Directed self-checking bench for ycbcr2rgb (default swap_uv and swap_uv=1 instances share stimulus).
module tb_ycbcr2rgb;
  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        hs = 1'b0, vs = 1'b0, de = 1'b0;
  logic [17:0] ycc = '0;
  logic        o_hs, o_vs, o_de, s_hs, s_vs, s_de;
  logic [23:0] o_rgb, s_rgb;
  int          n_cmp = 0;
  int          n_bad = 0;

  always #5 clk = ~clk;

  ycbcr2rgb #(.swap_uv(1'b0)) dut (
    .i_clk(clk), .i_rst(rst), .i_hsync(hs), .i_vsync(vs), .i_de(de), .i_YCbCr(ycc),
    .o_hsync(o_hs), .o_vsync(o_vs), .o_de(o_de), .o_rgb(o_rgb)
  );

  ycbcr2rgb #(.swap_uv(1'b1)) dut_sw (
    .i_clk(clk), .i_rst(rst), .i_hsync(hs), .i_vsync(vs), .i_de(de), .i_YCbCr(ycc),
    .o_hsync(s_hs), .o_vsync(s_vs), .o_de(s_de), .o_rgb(s_rgb)
  );

  // Upper two bits set to junk on purpose: they must be ignored.
  task automatic drive(input logic [7:0] y, input logic [7:0] c, input logic d);
    ycc = {2'b11, y, c};
    de  = d;
  endtask

  task automatic test_reset;
    rst = 1'b1;
    hs  = 1'b1;
    vs  = 1'b1;
    drive(8'hFF, 8'hFF, 1'b1);
    repeat (3) @(posedge clk);
    #1;
    n_cmp++; if (o_rgb !== 24'h0) begin n_bad++; $display("FAIL reset_rgb got %h want 000000", o_rgb); end
    n_cmp++; if (o_de !== 1'b0) begin n_bad++; $display("FAIL reset_de got %b want 0", o_de); end
    n_cmp++; if (o_hs !== 1'b0) begin n_bad++; $display("FAIL reset_hsync got %b want 0", o_hs); end
    n_cmp++; if (o_vs !== 1'b0) begin n_bad++; $display("FAIL reset_vsync got %b want 0", o_vs); end
    n_cmp++; if (s_rgb !== 24'h0) begin n_bad++; $display("FAIL reset_rgb_sw got %h want 000000", s_rgb); end
    rst = 1'b0;
    hs  = 1'b0;
    vs  = 1'b0;
    drive(8'h00, 8'hFF, 1'b0);
    repeat (6) @(posedge clk);
    #1;
  endtask

  task automatic test_black_white;
    logic [7:0]  ty[8];
    logic [23:0] er[8];
    logic [23:0] exp_rgb;
    int          v;
    ty = '{8'd16, 8'd16, 8'd16, 8'd16, 8'd235, 8'd235, 8'd235, 8'd235};
    er = '{24'h000000, 24'h000000, 24'h000000, 24'h000000,
           24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF, 24'hFFFFFF};
    for (int c = 0; c < 13; c++) begin
      if (c < 8) drive(ty[c], 8'd128, 1'b1);
      else       drive(8'h00, 8'hFF, 1'b0);
      @(posedge clk);
      #1;
      if (c >= 4) begin
        v = c - 4;
        exp_rgb = (v < 8) ? er[v] : 24'h0;
        n_cmp++; if (o_rgb !== exp_rgb) begin n_bad++; $display("FAIL bw_rgb[%0d] got %h want %h", v, o_rgb, exp_rgb); end
        n_cmp++; if (o_de !== (v < 8)) begin n_bad++; $display("FAIL bw_de[%0d] got %b want %b", v, o_de, (v < 8)); end
      end
    end
  endtask

  task automatic test_red;
    logic [7:0] tc[2];
    int         v;
    tc = '{8'd90, 8'd240};
    for (int c = 0; c < 7; c++) begin
      if (c < 2) drive(8'd81, tc[c], 1'b1);
      else       drive(8'h00, 8'hFF, 1'b0);
      @(posedge clk);
      #1;
      if (c >= 4) begin
        v = c - 4;
        if (v < 2) begin
          n_cmp++; if (o_rgb !== 24'hFF0000) begin n_bad++; $display("FAIL red_rgb[%0d] got %h want FF0000", v, o_rgb); end
          n_cmp++; if (s_rgb !== 24'h0F3FFF) begin n_bad++; $display("FAIL red_swap_rgb[%0d] got %h want 0F3FFF", v, s_rgb); end
        end else begin
          n_cmp++; if (o_rgb !== 24'h0) begin n_bad++; $display("FAIL red_idle_rgb[%0d] got %h want 000000", v, o_rgb); end
        end
      end
    end
  endtask

  task automatic test_odd_line;
    logic [7:0]  ty[7], tc[7];
    logic        td[7];
    logic [23:0] er[7];
    logic [23:0] exp_rgb;
    int          v;
    ty = '{8'd126, 8'd126, 8'd126, 8'd0,  8'd0,  8'd81,  8'd81};
    tc = '{8'd128, 8'd240, 8'd128, 8'hFF, 8'hFF, 8'd90,  8'd240};
    td = '{1'b1,   1'b1,   1'b1,   1'b0,  1'b0,  1'b1,   1'b1};
    er = '{24'hFF2580, 24'hFF2580, 24'h808080, 24'h0, 24'h0, 24'hFF0000, 24'hFF0000};
    for (int c = 0; c < 12; c++) begin
      if (c < 7) drive(ty[c], tc[c], td[c]);
      else       drive(8'h00, 8'hFF, 1'b0);
      @(posedge clk);
      #1;
      if (c >= 4) begin
        v = c - 4;
        exp_rgb = (v < 7) ? er[v] : 24'h0;
        n_cmp++; if (o_rgb !== exp_rgb) begin n_bad++; $display("FAIL odd_rgb[%0d] got %h want %h", v, o_rgb, exp_rgb); end
      end
    end
  endtask

  task automatic test_sync;
    logic [15:0] l;
    logic        hh[64], vh[64], dh[64];
    logic [23:0] exp_rgb;
    int          v;
    l = 16'hACE1;
    for (int c = 0; c < 64; c++) begin
      if (c < 59) begin
        l = {l[14:0], l[15] ^ l[13] ^ l[12] ^ l[10]};
        hh[c] = l[0];
        vh[c] = l[5];
        dh[c] = l[9];
      end else begin
        hh[c] = 1'b0;
        vh[c] = 1'b0;
        dh[c] = 1'b0;
      end
      hs = hh[c];
      vs = vh[c];
      drive(8'd255, 8'd128, dh[c]);
      @(posedge clk);
      #1;
      if (c >= 4) begin
        v = c - 4;
        exp_rgb = dh[v] ? 24'hFFFFFF : 24'h0;
        n_cmp++; if (o_hs !== hh[v]) begin n_bad++; $display("FAIL sync_hsync[%0d] got %b want %b", v, o_hs, hh[v]); end
        n_cmp++; if (o_vs !== vh[v]) begin n_bad++; $display("FAIL sync_vsync[%0d] got %b want %b", v, o_vs, vh[v]); end
        n_cmp++; if (o_de !== dh[v]) begin n_bad++; $display("FAIL sync_de[%0d] got %b want %b", v, o_de, dh[v]); end
        n_cmp++; if (o_rgb !== exp_rgb) begin n_bad++; $display("FAIL sync_rgb[%0d] got %h want %h", v, o_rgb, exp_rgb); end
      end
    end
    drive(8'h00, 8'hFF, 1'b0);
  endtask

  task automatic test_reset_midline;
    localparam int N = 1920;
    logic [23:0] exp_rgb;
    logic        exp_de;
    logic [7:0]  tc[4];
    int          v, k;
    for (int c = 0; c < N + 5; c++) begin
      rst = (c == 20);
      if (c <= 20) drive(8'd235, 8'd128, 1'b1);
      else if (c < N) begin
        k = c - 21;
        drive(8'd81, (k % 2 == 1) ? 8'd240 : 8'd90, 1'b1);
      end else drive(8'h00, 8'hFF, 1'b0);
      @(posedge clk);
      #1;
      if (c >= 4) begin
        v = c - 4;
        if (c >= 20 && v <= 20) begin exp_rgb = 24'h0; exp_de = 1'b0; end
        else if (v < 20)        begin exp_rgb = 24'hFFFFFF; exp_de = 1'b1; end
        else if (v < N)         begin exp_rgb = (v == N - 1) ? 24'h4C5B00 : 24'hFF0000; exp_de = 1'b1; end
        else                    begin exp_rgb = 24'h0; exp_de = 1'b0; end
        n_cmp++; if (o_rgb !== exp_rgb) begin n_bad++; $display("FAIL midrst_rgb[%0d] got %h want %h", v, o_rgb, exp_rgb); end
        n_cmp++; if (o_de !== exp_de) begin n_bad++; $display("FAIL midrst_de[%0d] got %b want %b", v, o_de, exp_de); end
      end
    end
    rst = 1'b0;
    tc = '{8'd90, 8'd240, 8'd90, 8'd240};
    for (int c = 0; c < 9; c++) begin
      if (c < 4) drive(8'd81, tc[c], 1'b1);
      else       drive(8'h00, 8'hFF, 1'b0);
      @(posedge clk);
      #1;
      if (c >= 4 && c - 4 < 4) begin
        n_cmp++; if (o_rgb !== 24'hFF0000) begin n_bad++; $display("FAIL midrst_next_rgb[%0d] got %h want FF0000", c - 4, o_rgb); end
      end
    end
  endtask

  task automatic test_fullrange;
    logic [7:0]  ty[6], tc[6];
    logic [23:0] er[6];
    logic [23:0] exp_rgb;
    int          v;
    ty = '{8'd255, 8'd255, 8'd0, 8'd0, 8'd76, 8'd76};
    tc = '{8'd128, 8'd128, 8'd128, 8'd128, 8'd85, 8'd255};
    er = '{24'hFFFFFF, 24'hFFFFFF, 24'h000000, 24'h000000, 24'hFE0000, 24'hFE0000};
    for (int c = 0; c < 11; c++) begin
      if (c < 6) drive(ty[c], tc[c], 1'b1);
      else       drive(8'h00, 8'hFF, 1'b0);
      @(posedge clk);
      #1;
      if (c >= 4) begin
        v = c - 4;
        exp_rgb = (v < 6) ? er[v] : 24'h0;
        n_cmp++; if (o_rgb !== exp_rgb) begin n_bad++; $display("FAIL full_rgb[%0d] got %h want %h", v, o_rgb, exp_rgb); end
      end
    end
  endtask

  initial begin
    test_reset;
    test_sync;
`ifdef YCBCR2RGB_FULLRANGE_EN
    test_fullrange;
`else
    test_black_white;
    test_red;
    test_odd_line;
    test_reset_midline;
`endif
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end
endmodule
